// File: rtl/lsu_dmem.sv
// Load/store unit in front of a word-organised data memory with byte lanes.
// One outstanding request, fixed LATENCY to response, response held until consumed.
module lsu_dmem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [2:0]    cnt, cnt_nxt;
  logic          accept;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          align_err, range_err, fault;
  logic          wr_en;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;
  logic [31:0]   rd_word, rd_shift, ext_data, load_data;
  logic [31:0]   rdata_q;
  logic          fault_q;

  logic [31:0] mem [DEPTH_WORDS];

  assign accept    = req_valid && req_ready;
  assign idx       = req_addr[AW+1:2];
  assign lane      = req_addr[1:0];
  assign range_err = (req_addr[31:AW+2] != '0);
  assign fault     = align_err || range_err;
  assign wr_en     = accept && req_write && !fault;

  always_comb begin
    align_err = 1'b0;
    be        = 4'b0000;
    wdata_rep = req_wdata;
    case (req_size)
      2'b00: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        align_err = lane[0];
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        align_err = (lane != 2'b00);
        be        = 4'b1111;
      end
      default: align_err = 1'b1;
    endcase
  end

  // Storage has no reset; only the addressed lanes of a non-faulting store change.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  assign rd_word  = mem[idx];
  assign rd_shift = rd_word >> {lane, 3'b000};

  always_comb begin
    case (req_size)
      2'b00:   ext_data = req_unsigned ? {24'h0, rd_shift[7:0]}
                                       : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   ext_data = req_unsigned ? {16'h0, rd_shift[15:0]}
                                       : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: ext_data = rd_word;
    endcase
  end

  assign load_data = (req_write || fault) ? 32'h0 : ext_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
    end else if (accept) begin
      rdata_q <= load_data;
      fault_q <= fault;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt holds the WAIT cycles still to go; the last one moves to RESP.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 3'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt <= 3'd1) begin
          state_nxt = RESP;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  assign req_ready = (state == IDLE) && reset_n;
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_fault = fault_q;

endmodule

// File: tb/tb_lsu_dmem.sv
// Bench for lsu_dmem: instance 0 with LATENCY=1, instance 1 with LATENCY=3, byte-array reference model.
module tb_lsu_dmem;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_write    [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [31:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic        rsp_valid    [2];
  logic        rsp_ready    [2];
  logic [31:0] rsp_rdata    [2];
  logic        rsp_fault    [2];

  int errors = 0;
  int checks = 0;

  logic [7:0] mmem [2][4096];

  always #5 clock = ~clock;

  lsu_dmem #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_fault(rsp_fault[0])
  );

  lsu_dmem #(.DEPTH_WORDS(1024), .LATENCY(3)) dut3 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_fault(rsp_fault[1])
  );

  // Reference: memory is a flat byte array, little-endian, 4096 bytes per instance.
  function automatic void model_op(input int d, input bit wr, input bit [1:0] sz, input bit uns,
                                   input bit [31:0] a, input bit [31:0] wd,
                                   output bit [31:0] rd, output bit flt);
    int n;
    longint v;
    flt = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (a >= 32'd4096);
    rd = 32'h0;
    if (flt) return;
    n = 1 << sz;
    if (wr) begin
      for (int i = 0; i < n; i++) mmem[d][int'(a) + i] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v | (longint'(mmem[d][int'(a) + i]) << (8*i));
      if (!uns && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8*n));
      rd = v[31:0];
    end
  endfunction

  // Drives one request, waits for the response, holds rsp_ready low for 'hold' cycles.
  task automatic do_txn(input int d, input bit wr, input bit [1:0] sz, input bit uns,
                        input bit [31:0] a, input bit [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic flt, output int lat,
                        output bit stable_ok, output bit rdy_ok);
    @(negedge clock);
    rdy_ok = (req_ready[d] === 1'b1);
    req_valid[d] = 1'b1; req_write[d] = wr; req_size[d] = sz;
    req_unsigned[d] = uns; req_addr[d] = a; req_wdata[d] = wd;
    @(posedge clock);
    #1;
    req_valid[d] = 1'b0; req_write[d] = 1'($urandom); req_size[d] = 2'($urandom);
    req_unsigned[d] = 1'($urandom); req_addr[d] = $urandom; req_wdata[d] = $urandom;
    lat = 1;
    @(negedge clock);
    while (rsp_valid[d] !== 1'b1 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    rd = rsp_rdata[d];
    flt = rsp_fault[d];
    stable_ok = 1'b1;
    if (req_ready[d] !== 1'b0) rdy_ok = 1'b0;
    repeat (hold) begin
      @(negedge clock);
      if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== rd || rsp_fault[d] !== flt) stable_ok = 1'b0;
      if (req_ready[d] !== 1'b0) rdy_ok = 1'b0;
    end
    rsp_ready[d] = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready[d] = 1'b0;
    @(negedge clock);
    if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) stable_ok = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b0 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'h0 || rsp_fault[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: ready=%b valid=%b rdata=%h fault=%b, want 0 0 0 0",
                 d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_fault[d]);
      end
    end
    reset_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_release_ready dut%0d: got %b want 1", d, req_ready[d]);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic flt; int lat; bit st, rk; bit [31:0] erd; bit eflt;
    model_op(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, erd, eflt);
    do_txn(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, rd, flt, lat, st, rk);
    checks++;
    if (rd !== 32'h0 || flt !== 1'b0 || lat != 1) begin
      errors++;
      $display("FAIL sw_10: rdata=%h fault=%b lat=%0d, want 00000000 0 1", rd, flt, lat);
    end
    model_op(0, 0, 2'd2, 0, 32'h10, 32'h0, erd, eflt);
    do_txn(0, 0, 2'd2, 0, 32'h10, 32'h0, 0, rd, flt, lat, st, rk);
    checks++;
    if (rd !== 32'hDEADBEEF || flt !== 1'b0 || lat != 1 || !st || !rk) begin
      errors++;
      $display("FAIL lw_10: rdata=%h fault=%b lat=%0d stable=%b rdy=%b, want deadbeef 0 1 1 1",
               rd, flt, lat, st, rk);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic flt; int lat; bit st, rk; bit [31:0] erd; bit eflt;
    model_op(0, 1, 2'd0, 0, 32'h13, 32'h7F, erd, eflt);
    do_txn(0, 1, 2'd0, 0, 32'h13, 32'hFFFFFF7F, 1, rd, flt, lat, st, rk);
    model_op(0, 0, 2'd0, 0, 32'h13, 32'h0, erd, eflt);
    do_txn(0, 0, 2'd0, 0, 32'h13, 32'h0, 0, rd, flt, lat, st, rk);
    checks++;
    if (rd !== 32'h0000007F || flt !== 1'b0) begin
      errors++;
      $display("FAIL lb_13: got %h/%b want 0000007f/0", rd, flt);
    end
    do_txn(0, 0, 2'd2, 0, 32'h10, 32'h0, 0, rd, flt, lat, st, rk);
    checks++;
    if (rd !== 32'h7FADBEEF) begin
      errors++;
      $display("FAIL lw_10_after_sb: got %h want 7fadbeef", rd);
    end
    model_op(0, 1, 2'd0, 0, 32'h12, 32'h80, erd, eflt);
    do_txn(0, 1, 2'd0, 0, 32'h12, 32'h80, 0, rd, flt, lat, st, rk);
    do_txn(0, 0, 2'd0, 0, 32'h12, 32'h0, 0, rd, flt, lat, st, rk);
    checks++;
    if (rd !== 32'hFFFFFF80) begin
      errors++;
      $display("FAIL lb_12: got %h want ffffff80", rd);
    end
    do_txn(0, 0, 2'd0, 1, 32'h12, 32'h0, 0, rd, flt, lat, st, rk);
    checks++;
    if (rd !== 32'h00000080) begin
      errors++;
      $display("FAIL lbu_12: got %h want 00000080", rd);
    end
  endtask

  task automatic test_fault();
    logic [31:0] rd; logic flt; int lat; bit st, rk;
    do_txn(0, 1, 2'd1, 0, 32'h11, 32'h1234, 0, rd, flt, lat, st, rk);
    checks++;
    if (flt !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL sh_misaligned: fault=%b rdata=%h want 1 00000000", flt, rd);
    end
    do_txn(0, 0, 2'd2, 0, 32'h10, 32'h0, 0, rd, flt, lat, st, rk);
    checks++;
    if (rd !== 32'h7F80BEEF || flt !== 1'b0) begin
      errors++;
      $display("FAIL mem_unchanged_after_fault: got %h/%b want 7f80beef/0", rd, flt);
    end
    do_txn(0, 0, 2'd2, 0, 32'h1000, 32'h0, 0, rd, flt, lat, st, rk);
    checks++;
    if (flt !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL lw_out_of_range: fault=%b rdata=%h want 1 00000000", flt, rd);
    end
    do_txn(0, 0, 2'd3, 0, 32'h10, 32'h0, 0, rd, flt, lat, st, rk);
    checks++;
    if (flt !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL size_11: fault=%b rdata=%h want 1 00000000", flt, rd);
    end
  endtask

  task automatic test_latency3();
    logic [31:0] rd; logic flt; int lat; bit st, rk; bit [31:0] erd; bit eflt;
    model_op(1, 1, 2'd2, 0, 32'h40, 32'hCAFEF00D, erd, eflt);
    do_txn(1, 1, 2'd2, 0, 32'h40, 32'hCAFEF00D, 5, rd, flt, lat, st, rk);
    checks++;
    if (lat != 3 || !st || !rk || rd !== 32'h0 || flt !== 1'b0) begin
      errors++;
      $display("FAIL lat3_sw: lat=%0d stable=%b rdy=%b rdata=%h fault=%b want 3 1 1 0 0",
               lat, st, rk, rd, flt);
    end
    do_txn(1, 0, 2'd2, 0, 32'h40, 32'h0, 5, rd, flt, lat, st, rk);
    checks++;
    if (lat != 3 || !st || !rk || rd !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL lat3_lw: lat=%0d stable=%b rdy=%b rdata=%h want 3 1 1 cafef00d", lat, st, rk, rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic flt; int lat; bit st, rk; bit [31:0] erd; bit eflt; bit seen;
    model_op(1, 1, 2'd2, 0, 32'h20, 32'h55AA55AA, erd, eflt);
    @(negedge clock);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_size[1] = 2'd2;
    req_unsigned[1] = 1'b0; req_addr[1] = 32'h20; req_wdata[1] = 32'h55AA55AA;
    @(posedge clock);
    #1;
    req_valid[1] = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if (req_ready[1] !== 1'b0 || rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 32'h0 || rsp_fault[1] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: ready=%b valid=%b rdata=%h fault=%b want 0 0 0 0",
               req_ready[1], rsp_valid[1], rsp_rdata[1], rsp_fault[1]);
    end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checks++;
    if (req_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_ready: got %b want 1", req_ready[1]);
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (rsp_valid[1] !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_reset_dropped: rsp_valid seen=%b want 0", seen);
    end
    do_txn(1, 0, 2'd2, 0, 32'h20, 32'h0, 0, rd, flt, lat, st, rk);
    checks++;
    if (rd !== 32'h55AA55AA || flt !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_store_kept: got %h/%b want 55aa55aa/0", rd, flt);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd; logic flt; int lat; bit st, rk; bit [31:0] erd; bit eflt;
    bit wr; bit [1:0] sz; bit uns; bit [31:0] a, wd; int d, hold;
    for (int di = 0; di < 2; di++) begin
      for (int w = 0; w < 32; w++) begin
        wd = $urandom;
        model_op(di, 1, 2'd2, 0, 32'(w * 4), wd, erd, eflt);
        do_txn(di, 1, 2'd2, 0, 32'(w * 4), wd, 0, rd, flt, lat, st, rk);
        checks++;
        if (flt !== eflt || rd !== erd) begin
          errors++;
          $display("FAIL preload dut%0d w%0d: got %h/%b want %h/%b", di, w, rd, flt, erd, eflt);
        end
      end
    end
    for (int k = 0; k < 200; k++) begin
      d = int'($urandom_range(0, 1));
      wr = 1'($urandom); sz = 2'($urandom); uns = 1'($urandom); wd = $urandom;
      a = ($urandom_range(0, 7) == 0) ? (32'h1000 | $urandom) : 32'($urandom_range(0, 127));
      hold = int'($urandom_range(0, 3));
      model_op(d, wr, sz, uns, a, wd, erd, eflt);
      do_txn(d, wr, sz, uns, a, wd, hold, rd, flt, lat, st, rk);
      checks++;
      if (rd !== erd || flt !== eflt || lat != (d == 0 ? 1 : 3) || !st || !rk) begin
        errors++;
        $display("FAIL random#%0d dut%0d wr=%b sz=%0d u=%b a=%h: got %h/%b lat=%0d st=%b rk=%b want %h/%b lat=%0d",
                 k, d, wr, sz, uns, a, rd, flt, lat, st, rk, erd, eflt, (d == 0 ? 1 : 3));
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_size[d] = 2'd0; req_unsigned[d] = 1'b0;
      req_addr[d] = 32'h0; req_wdata[d] = 32'h0; rsp_ready[d] = 1'b0;
    end
    test_reset();
    test_basic();
    test_byte_lanes();
    test_fault();
    test_latency3();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
